// File: rtl/vram_arb.sv
// VRAM arbiter: video has absolute priority, regs and blit share the rest round-robin.
// Grants are combinational; read data returns one cycle later, tagged to the winner.
module vram_arb #(
   parameter int STALL_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               vid_req_i,
   input  logic [15:0]        vid_addr_i,
   output logic               vid_ack_o,
   output logic               vid_rd_valid_o,
   input  logic               regs_req_i,
   input  logic               regs_wr_i,
   input  logic [15:0]        regs_addr_i,
   input  logic [15:0]        regs_data_i,
   output logic               regs_ack_o,
   output logic               regs_rd_valid_o,
   input  logic               blit_req_i,
   input  logic               blit_wr_i,
   input  logic [15:0]        blit_addr_i,
   input  logic [15:0]        blit_data_i,
   output logic               blit_ack_o,
   output logic               blit_rd_valid_o,
   output logic               vram_sel_o,
   output logic               vram_wr_o,
   output logic [15:0]        vram_addr_o,
   output logic [15:0]        vram_data_o,
   input  logic [15:0]        vram_data_i,
   output logic [15:0]        rd_data_o,
   output logic [STALL_W-1:0] stall_cnt_o
);

   typedef enum logic [1:0] {SRC_NONE, SRC_VID, SRC_REGS, SRC_BLIT} src_t;

   src_t               gnt;
   src_t               rd_tag;
   logic               blit_last;   // 1: blit won the last regs/blit grant, so regs wins a tie
   logic [STALL_W-1:0] stall_cnt;
   logic [1:0]         req_cnt;
   logic               denied;
   logic               rd_any;

   always_comb begin
      gnt = SRC_NONE;
      if (!reset) begin
         if (vid_req_i)                    gnt = SRC_VID;
         else if (regs_req_i && blit_req_i) gnt = blit_last ? SRC_REGS : SRC_BLIT;
         else if (regs_req_i)              gnt = SRC_REGS;
         else if (blit_req_i)              gnt = SRC_BLIT;
      end
   end

   always_comb begin
      vid_ack_o   = (gnt == SRC_VID);
      regs_ack_o  = (gnt == SRC_REGS);
      blit_ack_o  = (gnt == SRC_BLIT);
      vram_sel_o  = (gnt != SRC_NONE);
      vram_wr_o   = 1'b0;
      vram_addr_o = '0;
      vram_data_o = '0;
      case (gnt)
         SRC_VID:  vram_addr_o = vid_addr_i;
         SRC_REGS: begin
            vram_wr_o   = regs_wr_i;
            vram_addr_o = regs_addr_i;
            vram_data_o = regs_data_i;
         end
         SRC_BLIT: begin
            vram_wr_o   = blit_wr_i;
            vram_addr_o = blit_addr_i;
            vram_data_o = blit_data_i;
         end
         default: ;
      endcase
   end

   // With one grant per cycle, a request is denied whenever requests outnumber grants.
   assign req_cnt = {1'b0, vid_req_i} + {1'b0, regs_req_i} + {1'b0, blit_req_i};
   assign denied  = req_cnt > {1'b0, vram_sel_o};

   always_ff @(posedge clk) begin
      if (reset) begin
         blit_last <= 1'b1;
         rd_tag    <= SRC_NONE;
         stall_cnt <= '0;
      end else begin
         if (gnt == SRC_REGS) blit_last <= 1'b0;
         if (gnt == SRC_BLIT) blit_last <= 1'b1;
         rd_tag <= (gnt != SRC_NONE && !vram_wr_o) ? gnt : SRC_NONE;
         if (denied && stall_cnt != '1)
            stall_cnt <= stall_cnt + {{(STALL_W-1){1'b0}}, 1'b1};
      end
   end

   // Gating with reset drops a read whose data would land in the reset cycle.
   assign rd_any          = !reset && rd_tag != SRC_NONE;
   assign vid_rd_valid_o  = !reset && rd_tag == SRC_VID;
   assign regs_rd_valid_o = !reset && rd_tag == SRC_REGS;
   assign blit_rd_valid_o = !reset && rd_tag == SRC_BLIT;
   assign rd_data_o       = rd_any ? vram_data_i : '0;
   assign stall_cnt_o     = stall_cnt;

endmodule

// File: tb/tb_vram_arb.sv
// Bench for vram_arb: directed scenarios plus random traffic, checked cycle by cycle
// against a priority/round-robin reference model and a behavioural VRAM.
module tb_vram_arb;
   localparam int SW = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          vid_req_i, regs_req_i, regs_wr_i, blit_req_i, blit_wr_i;
   logic [15:0]   vid_addr_i, regs_addr_i, regs_data_i, blit_addr_i, blit_data_i;
   logic          vid_ack_o, vid_rd_valid_o, regs_ack_o, regs_rd_valid_o;
   logic          blit_ack_o, blit_rd_valid_o, vram_sel_o, vram_wr_o;
   logic [15:0]   vram_addr_o, vram_data_o, vram_data_i, rd_data_o;
   logic [SW-1:0] stall_cnt_o;

   vram_arb #(.STALL_W(SW)) dut (
      .clk(clk), .reset(reset),
      .vid_req_i(vid_req_i), .vid_addr_i(vid_addr_i), .vid_ack_o(vid_ack_o),
      .vid_rd_valid_o(vid_rd_valid_o),
      .regs_req_i(regs_req_i), .regs_wr_i(regs_wr_i), .regs_addr_i(regs_addr_i),
      .regs_data_i(regs_data_i), .regs_ack_o(regs_ack_o), .regs_rd_valid_o(regs_rd_valid_o),
      .blit_req_i(blit_req_i), .blit_wr_i(blit_wr_i), .blit_addr_i(blit_addr_i),
      .blit_data_i(blit_data_i), .blit_ack_o(blit_ack_o), .blit_rd_valid_o(blit_rd_valid_o),
      .vram_sel_o(vram_sel_o), .vram_wr_o(vram_wr_o), .vram_addr_o(vram_addr_o),
      .vram_data_o(vram_data_o), .vram_data_i(vram_data_i),
      .rd_data_o(rd_data_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk = ~clk;

   // Synchronous VRAM with registered read data.
   logic [15:0] mem [0:65535];
   always @(posedge clk) begin
      if (vram_sel_o) begin
         if (vram_wr_o) mem[vram_addr_o] <= vram_data_o;
         else           vram_data_i      <= mem[vram_addr_o];
      end
   end

   // Reference model state: winner codes 0 none, 1 vid, 2 regs, 3 blit.
   int          checks = 0, errors = 0;
   int          m_last_blit = 1, m_tag = 0, m_stall = 0, m_win = 0;
   logic [15:0] m_tag_data = '0;
   logic [2:0]  last_acks;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1 with inputs applied; checks this cycle, then advances the model.
   task automatic tick();
      int w, nreq;
      logic wr;
      logic [15:0] a, d;
      #3;
      w = 0;
      if (!reset) begin
         if (vid_req_i)                     w = 1;
         else if (regs_req_i && blit_req_i) w = m_last_blit ? 2 : 3;
         else if (regs_req_i)               w = 2;
         else if (blit_req_i)               w = 3;
      end
      wr = 1'b0; a = '0; d = '0;
      case (w)
         1: a = vid_addr_i;
         2: begin wr = regs_wr_i; a = regs_addr_i; d = regs_data_i; end
         3: begin wr = blit_wr_i; a = blit_addr_i; d = blit_data_i; end
         default: ;
      endcase
      chk("vid_ack",   vid_ack_o,   w == 1);
      chk("regs_ack",  regs_ack_o,  w == 2);
      chk("blit_ack",  blit_ack_o,  w == 3);
      chk("vram_sel",  vram_sel_o,  w != 0);
      chk("vram_wr",   vram_wr_o,   wr);
      chk("vram_addr", vram_addr_o, a);
      chk("vram_data", vram_data_o, d);
      chk("vid_rdv",   vid_rd_valid_o,  !reset && m_tag == 1);
      chk("regs_rdv",  regs_rd_valid_o, !reset && m_tag == 2);
      chk("blit_rdv",  blit_rd_valid_o, !reset && m_tag == 3);
      chk("rd_data",   rd_data_o, (!reset && m_tag != 0) ? m_tag_data : 16'h0);
      chk("stall_cnt", stall_cnt_o, m_stall);
      last_acks = {vid_ack_o, regs_ack_o, blit_ack_o};
      m_win = w;
      if (reset) begin
         m_tag = 0; m_stall = 0; m_last_blit = 1;
      end else begin
         m_tag      = (w != 0 && !wr) ? w : 0;
         m_tag_data = mem[a];
         if (w == 2) m_last_blit = 0;
         if (w == 3) m_last_blit = 1;
         nreq = int'(vid_req_i) + int'(regs_req_i) + int'(blit_req_i);
         if (nreq > ((w != 0) ? 1 : 0) && m_stall < (1 << SW) - 1) m_stall++;
      end
      @(posedge clk); #1;
   endtask

   task automatic idle_reqs();
      vid_req_i = 0; regs_req_i = 0; blit_req_i = 0;
   endtask

   task automatic do_reset();
      idle_reqs();
      reset = 1; tick(); reset = 0;
   endtask

   task automatic blit_write(input logic [15:0] a, input logic [15:0] d);
      blit_req_i = 1; blit_wr_i = 1; blit_addr_i = a; blit_data_i = d;
      tick();
      blit_req_i = 0;
   endtask

   initial begin
      logic [2:0] alt [4];
      reset = 1; idle_reqs();
      regs_wr_i = 0; blit_wr_i = 0; vid_addr_i = '0; regs_addr_i = '0;
      regs_data_i = '0; blit_addr_i = '0; blit_data_i = '0;
      @(posedge clk); @(posedge clk); #1;
      tick();
      reset = 0;

      // Regs read returns data one cycle after its grant.
      blit_write(16'h1234, 16'hBEEF);
      regs_req_i = 1; regs_wr_i = 0; regs_addr_i = 16'h1234;
      tick();
      chk("r19_ack", last_acks, 3'b010);
      regs_req_i = 0;
      chk("r19_rdv",  regs_rd_valid_o, 1'b1);
      chk("r19_data", rd_data_o, 16'hBEEF);
      tick();

      // Video wins against both others for three cycles.
      vid_req_i = 1; vid_addr_i = 16'h0040;
      regs_req_i = 1; regs_wr_i = 0; blit_req_i = 1; blit_wr_i = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("r20_ack", last_acks, 3'b100);
      end
      chk("r20_stall", stall_cnt_o, 3);
      idle_reqs();
      tick();

      // Round-robin alternation after reset.
      do_reset();
      alt[0] = 3'b010; alt[1] = 3'b001; alt[2] = 3'b010; alt[3] = 3'b001;
      regs_req_i = 1; regs_wr_i = 0; regs_addr_i = 16'h0002;
      blit_req_i = 1; blit_wr_i = 0; blit_addr_i = 16'h0003;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("r21_alt", last_acks, alt[i]);
      end
      idle_reqs();
      tick();

      // Write then read the same address on consecutive cycles.
      blit_write(16'hF000, 16'h5A5A);
      chk("r22_wack", last_acks, 3'b001);
      regs_req_i = 1; regs_wr_i = 0; regs_addr_i = 16'hF000;
      chk("r22_no_rdv", {vid_rd_valid_o, regs_rd_valid_o, blit_rd_valid_o}, 3'b000);
      tick();
      regs_req_i = 0;
      chk("r22_rdv",  regs_rd_valid_o, 1'b1);
      chk("r22_data", rd_data_o, 16'h5A5A);
      tick();

      // Stall counter saturates.
      vid_req_i = 1; vid_addr_i = 16'h0001; regs_req_i = 1; regs_wr_i = 1;
      for (int i = 0; i < (1 << SW) + 1; i++) tick();
      chk("r23_sat", stall_cnt_o, (1 << SW) - 1);
      tick();
      chk("r23_hold", stall_cnt_o, (1 << SW) - 1);

      // Reset right after a video read grant.
      regs_req_i = 0; vid_req_i = 1; vid_addr_i = 16'h0005;
      tick();
      vid_req_i = 0; reset = 1;
      #2;
      chk("r24_rdv_in_reset", vid_rd_valid_o, 1'b0);
      tick();
      reset = 0;
      chk("r24_rdv", vid_rd_valid_o, 1'b0);
      chk("r24_stall", stall_cnt_o, 0);
      regs_req_i = 1; regs_wr_i = 0; regs_addr_i = 16'h0004;
      blit_req_i = 1; blit_wr_i = 0; blit_addr_i = 16'h0006;
      tick();
      chk("r24_tie", last_acks, 3'b010);
      idle_reqs();
      tick();

      // Random traffic on a small address window; requests held until acked.
      for (int i = 0; i < 8; i++) blit_write(16'(i), 16'($urandom));
      for (int i = 0; i < 400; i++) begin
         if (!vid_req_i && $urandom_range(2, 0) == 0) begin
            vid_req_i = 1; vid_addr_i = 16'($urandom_range(7, 0));
         end
         if (!regs_req_i && $urandom_range(1, 0) == 0) begin
            regs_req_i = 1; regs_wr_i = 1'($urandom_range(1, 0));
            regs_addr_i = 16'($urandom_range(7, 0)); regs_data_i = 16'($urandom);
         end
         if (!blit_req_i && $urandom_range(1, 0) == 0) begin
            blit_req_i = 1; blit_wr_i = 1'($urandom_range(1, 0));
            blit_addr_i = 16'($urandom_range(7, 0)); blit_data_i = 16'($urandom);
         end
         tick();
         if (m_win == 1) vid_req_i = 0;
         if (m_win == 2) regs_req_i = 0;
         if (m_win == 3) blit_req_i = 0;
      end
      idle_reqs();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/vram_arb.md
VRAM_ARB -- requirements
Module: vram_arb

Interface
REQ-001 SHALL have parameter: STALL_W, 16, width of the saturating stall counter.
REQ-002 SHALL have a single clock domain; reset is synchronous and active-high.
REQ-003 SHALL have these ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- vid_req_i  in  1  video fetch read request
- vid_addr_i  in  16  video word address
- vid_ack_o  out  1  video request accepted this cycle
- vid_rd_valid_o  out  1  rd_data_o holds video data
- regs_req_i  in  1  CPU register-interface request
- regs_wr_i  in  1  1=write, 0=read (regs)
- regs_addr_i  in  16  regs word address
- regs_data_i  in  16  regs write data
- regs_ack_o  out  1  regs request accepted this cycle
- regs_rd_valid_o  out  1  rd_data_o holds regs data
- blit_req_i  in  1  blitter request
- blit_wr_i  in  1  1=write, 0=read (blit)
- blit_addr_i  in  16  blit word address
- blit_data_i  in  16  blit write data
- blit_ack_o  out  1  blit request accepted this cycle
- blit_rd_valid_o  out  1  rd_data_o holds blit data
- vram_sel_o  out  1  VRAM select
- vram_wr_o  out  1  VRAM write enable
- vram_addr_o  out  16  VRAM address
- vram_data_o  out  16  VRAM write data
- vram_data_i  in  16  VRAM registered read data
- rd_data_o  out  16  read data returned to the winning requester
- stall_cnt_o  out  STALL_W  saturating count of cycles with a denied request

Function
REQ-004 SHALL grant at most one requester per cycle; the grant and all vram_* outputs are combinational from the current requests and the round-robin state.
REQ-005 SHALL give video absolute priority: vid_req_i=1 always wins; video is read-only (vram_wr_o=0).
REQ-006 SHALL arbitrate regs versus blit round-robin when video is idle: with both requesting, grant the one not granted most recently; with one requesting, grant it.
REQ-007 SHALL update the round-robin pointer only on a regs or blit grant; a video grant leaves it unchanged.
REQ-008 SHALL assert the winner's ack_o in the grant cycle; the access occurs on that rising edge.
REQ-009 SHALL drive vram_sel_o=1 only when a grant occurs; otherwise vram_sel_o=0, vram_wr_o=0, and address/data are don't-care but held at 0.
REQ-010 SHALL make vram_wr_o equal the granted requester's wr_i, and vram_data_o equal its data_i.
REQ-011 SHALL register a one-cycle read tag; in the cycle after a granted read, the tagged requester's rd_valid_o=1 and rd_data_o=vram_data_i (latency 1).
REQ-012 SHALL not assert any rd_valid_o after a write grant; at most one rd_valid_o is high per cycle.
REQ-013 SHALL drive rd_data_o=0 when no rd_valid_o is asserted.
REQ-014 SHALL have requesters hold req_i, addr, wr and data stable until ack_o; a request dropped before ack is discarded without side effects.
REQ-015 SHALL support back-to-back grants every cycle, including read then write to the same address (the write follows the read; the read returns old data).
REQ-016 SHALL increment stall_cnt_o by 1 in any cycle where at least one request is not granted; the counter saturates at all-ones and never wraps.

Reset
REQ-017 SHALL, on reset, clear all rd_valid_o, the read tag, and stall_cnt_o, and set the round-robin pointer so that regs wins the first regs/blit tie.
REQ-018 SHALL, when reset is asserted, force all ack_o=0 and vram_sel_o=0 that cycle; a read granted the cycle before reset produces no rd_valid_o.

Verification
REQ-019 SHALL pass: reset, then regs read at 0x1234 with VRAM holding 0xBEEF -> regs_ack_o in cycle N; regs_rd_valid_o=1 and rd_data_o=0xBEEF in cycle N+1.
REQ-020 SHALL pass: vid, regs and blit all requesting for 3 cycles -> vid_ack_o every cycle, regs/blit acks 0, stall_cnt_o=3.
REQ-021 SHALL pass: after reset, regs and blit requesting continuously with video idle -> acks alternate regs, blit, regs, blit.
REQ-022 SHALL pass: blit writes 0x5A5A to 0xF000, then regs reads 0xF000 in the next cycle -> regs_rd_valid_o with rd_data_o=0x5A5A; no rd_valid_o after the write.
REQ-023 SHALL pass: stall_cnt_o preloaded to all-ones by 2^STALL_W stall cycles, then one more stall -> value stays all-ones.
REQ-024 SHALL pass: a video read is granted and reset is asserted the next cycle -> vid_rd_valid_o=0, stall_cnt_o=0, and after reset regs wins a regs/blit tie.
